uart_cmd_wrapper: RTL

//  Knight-side end of the remote command link, facing RemoteComm. Receives 8N1 UART

---
 rtl/uart_cmd_wrapper_if.sv | 35 +++
 rtl/uart_cmd_wrapper.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_wrapper_if.sv
// Command/response handshake bundle between the UART command wrapper
// (slave side) and the command processor (master side).
//
// Handshake semantics:
//   cmd_rdy is a level valid: when high, cmd holds a complete command and
//   stays stable until the next pair completes. The consumer acknowledges
//   with a 1-clk clr_cmd_rdy pulse. send_resp is a 1-clk request that is
//   accepted only while the transmitter is idle; resp_sent drops on
//   acceptance and rises again once the stop bit has been fully driven.
interface uart_cmd_wrapper_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;

  modport master (
    input  cmd,
    input  cmd_rdy,
    input  resp_sent,
    output clr_cmd_rdy,
    output resp,
    output send_resp
  );

  modport slave (
    output cmd,
    output cmd_rdy,
    output resp_sent,
    input  clr_cmd_rdy,
    input  resp,
    input  send_resp
  );
endinterface

// File: rtl/uart_cmd_wrapper.sv
// Knight-side UART command link: 8N1 receiver that pairs bytes (high first)
// into a 16-bit command, plus an independent 8N1 response transmitter.
// Optional feature macro: CMD_TIMEOUT_EN (discard a lone high byte when the
// low byte does not arrive within TIMEOUT_CLKS clocks).
// debug_state = {pair_state, rx_state[1:0], tx_state}.
module uart_cmd_wrapper #(
  parameter int CLKS_PER_BIT = 2604
`ifdef CMD_TIMEOUT_EN
  , parameter int TIMEOUT_CLKS = 2000000
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                RX,
  output logic                TX,
  uart_cmd_wrapper_if.slave   bus,
  output logic [3:0]          debug_state
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {WAIT_HI, WAIT_LO} pair_state_t;
  typedef enum logic {TX_IDLE, TX_TRANSMIT} tx_state_t;

  // ---------------- RX path ----------------
  logic            rx_meta;
  logic            rx_sync;
  logic            rx_prev;
  logic            rx_fall;
  rx_state_t       rx_state;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic            rx_tick;
  logic            byte_done;
  logic            start_det;

  // Two-flop synchronizer for the asynchronous RX line, plus a history flop
  // for falling-edge detection. Reset to idle-high so reset never fakes a start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall   = rx_prev & ~rx_sync;
  assign rx_tick   = (rx_cnt == '0);
  assign start_det = (rx_state == RX_IDLE) && rx_fall;
  // A good byte is reported in the same cycle its stop bit is sampled high.
  assign byte_done = (rx_state == RX_STOP) && rx_tick && rx_sync;

  // RX bit engine: half-bit wait to reach mid start bit, then full-bit steps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_cnt   <= HALF_BIT;
            rx_state <= RX_START;
          end
        end
        default: begin
          if (!rx_tick) begin
            rx_cnt <= rx_cnt - 1'b1;
          end else begin
            rx_cnt <= FULL_BIT;
            case (rx_state)
              RX_START: begin
                // Line must still be low mid start bit, otherwise it was a glitch.
                if (!rx_sync) begin
                  rx_bit   <= '0;
                  rx_state <= RX_DATA;
                end else begin
                  rx_state <= RX_IDLE;
                end
              end
              RX_DATA: begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
                if (rx_bit == 3'd7) begin
                  rx_state <= RX_STOP;
                end else begin
                  rx_bit <= rx_bit + 1'b1;
                end
              end
              default: begin
                // Stop bit sampled; a low stop bit simply drops the byte.
                rx_state <= RX_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  // ---------------- Pairing FSM ----------------
  pair_state_t  pair_state;
  logic [7:0]   hi_byte;
  logic [15:0]  cmd_q;
  logic         cmd_rdy_q;
  logic         timeout_hit;

`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
  logic [TW-1:0] tmo_cnt;

  assign timeout_hit = (pair_state == WAIT_LO) && !byte_done && (tmo_cnt == TMO_LAST);

  // Gap timer: runs only while a high byte is waiting for its partner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if ((pair_state == WAIT_LO) && !byte_done && !timeout_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Byte pairing: high byte first, command published when the low byte lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pair_state <= WAIT_HI;
      hi_byte    <= '0;
      cmd_q      <= '0;
      cmd_rdy_q  <= 1'b0;
    end else begin
      case (pair_state)
        WAIT_HI: begin
          if (byte_done) begin
            hi_byte    <= rx_shift;
            pair_state <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (byte_done) begin
            cmd_q      <= {hi_byte, rx_shift};
            pair_state <= WAIT_HI;
          end else if (timeout_hit) begin
            pair_state <= WAIT_HI;
          end
        end
        default: pair_state <= WAIT_HI;
      endcase

      // Completion of a new command beats a same-cycle clear.
      if ((pair_state == WAIT_LO) && byte_done) begin
        cmd_rdy_q <= 1'b1;
      end else if (bus.clr_cmd_rdy || (start_det && (pair_state == WAIT_HI))) begin
        cmd_rdy_q <= 1'b0;
      end
    end
  end

  // ---------------- TX path ----------------
  tx_state_t      tx_state;
  logic [9:0]     tx_shift;
  logic [CW-1:0]  tx_cnt;
  logic [3:0]     tx_bit;
  logic           tx_line;
  logic           resp_sent_q;

  // TX engine: frame {stop, data, start} shifted out LSB first, one bit per
  // CLKS_PER_BIT clocks; requests during a frame are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state    <= TX_IDLE;
      tx_shift    <= '1;
      tx_cnt      <= '0;
      tx_bit      <= '0;
      tx_line     <= 1'b1;
      resp_sent_q <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_line <= 1'b1;
          if (bus.send_resp) begin
            tx_shift    <= {1'b1, bus.resp, 1'b0};
            tx_line     <= 1'b0;
            tx_cnt      <= FULL_BIT;
            tx_bit      <= '0;
            resp_sent_q <= 1'b0;
            tx_state    <= TX_TRANSMIT;
          end
        end
        default: begin
          if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - 1'b1;
          end else if (tx_bit == 4'd9) begin
            tx_line     <= 1'b1;
            resp_sent_q <= 1'b1;
            tx_state    <= TX_IDLE;
          end else begin
            tx_bit   <= tx_bit + 1'b1;
            tx_shift <= {1'b1, tx_shift[9:1]};
            tx_line  <= tx_shift[1];
            tx_cnt   <= FULL_BIT;
          end
        end
      endcase
    end
  end

  assign TX            = tx_line;
  assign bus.cmd       = cmd_q;
  assign bus.cmd_rdy   = cmd_rdy_q;
  assign bus.resp_sent = resp_sent_q;
  assign debug_state   = {pair_state, rx_state, tx_state};

endmodule
